pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter sequencer for the processor core.
- Each cycle it takes the decoded instruction word and operands and produces the next fetch address.
- Resolves JR/JPC/BRFL/CALL/RET redirects, keeps its own return-address stack (RAS), and inserts a one-cycle flush bubble after every taken redirect.
- Detects RAS overflow/underflow and parks in a fault state until cleared.

Parameters:
- DWIDTH, 32, instruction/operand word width.
- AWIDTH, 15, program address width.
- RAS_DEPTH, 32, return-address stack entries; power of two, at least 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- instr_valid  input  1  instr/immediate/rd/flag hold a valid decoded instruction this cycle
- instr  input  DWIDTH  instruction word; opcode = instr[DWIDTH-1:DWIDTH-5]
- immediate  input  DWIDTH  sign-extended immediate
- rd  input  DWIDTH  register operand (absolute target)
- flag  input  1  condition flag for BRFL
- stall  input  1  hold PC, consume nothing
- fault_clr  input  1  leave FAULT, resume at pc
- pc  output  AWIDTH  current fetch address
- pc_valid  output  1  pc is a valid fetch this cycle
- flush  output  1  one-cycle pulse: discard in-flight fetch
- ras_full  output  1  RAS holds RAS_DEPTH entries
- ras_empty  output  1  RAS holds 0 entries
- fault  output  1  core is in FAULT
- fault_code  output  2  00 none, 01 RAS overflow, 10 RAS underflow

Behaviour:
- Reset: rst sampled on the clk rising edge only.
  - Reset values: pc=0, pc_valid=1, flush=0, fault=0, fault_code=00, ras_empty=1, ras_full=0.
  - RAS pointer cleared; state=RUN.
  - Reset mid-operation discards RAS contents and any pending flush.
- Opcodes: JR=01101, JPC=01110, BRFL=01111, CALL=10000, RET=10001. Any other opcode is sequential.
- States:
  - RUN: pc_valid=1.
  - FLUSH: pc_valid=0, lasts exactly 1 cycle, then RUN. instr_valid is ignored in FLUSH.
  - FAULT: pc_valid=0, pc held; exits to RUN on fault_clr=1.
- RUN, stall=1: nothing changes. stall has priority over instr_valid; no RAS access.
- RUN, instr_valid=0, stall=0: pc holds.
- RUN, instr_valid=1, stall=0 (all arithmetic mod 2^AWIDTH, truncate to AWIDTH bits):
  - Sequential: pc<=pc+1, stay RUN.
  - JR: pc<=rd[AWIDTH-1:0].
  - JPC: pc<=pc+immediate[AWIDTH-1:0]+1.
  - BRFL: if flag=1, pc<=rd[AWIDTH-1:0]; else pc<=pc+1 and it is treated as sequential.
  - CALL: push pc+1, then pc<=rd[AWIDTH-1:0].
  - RET: pop top, pc<=top.
- Taken redirects (JR, JPC, taken BRFL, CALL, RET):
  - flush=1 in the cycle after the update; state=FLUSH that same cycle.
- CALL with ras_full=1: no push, pc held, fault=1, fault_code=01 next cycle, state=FAULT, no flush.
- RET with ras_empty=1: pc held, fault_code=10, state=FAULT, no flush.
- FAULT:
  - fault_clr=1: fault and fault_code clear next cycle, state returns to RUN, pc unchanged, RAS contents preserved.
  - rst has priority over fault_clr.
- RAS status: ras_full and ras_empty are registered and reflect the count after each push/pop. Push and pop never occur in the same cycle.
- Latency: one cycle from an accepted instruction to the new pc.

Optional Feature:
- Macro: PC_SEQ_RAS_OVERWRITE_EN.
- Defined:
  - RAS is circular. CALL at full overwrites the oldest entry and does not fault; ras_full stays 1.
  - Overflow fault code 01 is never produced.
- Undefined: overflow faults as specified above.
- Underflow behaviour is identical in both builds.

Test Plan:
- Reset, then 3 sequential instructions -> pc 0,1,2,3; pc_valid=1; flush never asserted.
- pc=5, JPC immediate=10 -> pc=16, flush=1 for 1 cycle, pc_valid=0 for that cycle, then RUN.
- pc=7, BRFL rd=100 flag=0 -> pc=8, no flush. Same with flag=1 -> pc=100, flush pulse.
- pc=4, CALL rd=200 -> pc=200, ras_empty=0. Then RET -> pc=5, ras_empty=1.
- 32 CALLs, then a 33rd (macro off) -> fault=1, fault_code=01, pc held. fault_clr -> RUN at the same pc, ras_full=1. Macro on -> no fault.
- RET at reset -> fault_code=10. stall=1 held together with a CALL -> pc and RAS unchanged. rst during FAULT -> pc=0, fault=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoded-instruction / fetch-address bundle for the PC sequencer.
//
// Signals:
//   instr_valid, instr, immediate, rd, flag  decoded instruction and its operands
//   stall                                    hold the PC and consume nothing
//   fault_clr                                leave FAULT and resume at the held pc
//   pc, pc_valid                             current fetch address and its qualifier
//   flush                                    one-cycle pulse after every taken redirect
//   ras_full, ras_empty                      return-address stack status
//   fault, fault_code                        fault flag and cause (01 overflow, 10 underflow)
//
// Modports: master = decode side driving instructions, slave = the sequencer.

interface pc_sequencer_if #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned AWIDTH = 15
);
   logic              instr_valid;
   logic [DWIDTH-1:0] instr;
   logic [DWIDTH-1:0] immediate;
   logic [DWIDTH-1:0] rd;
   logic              flag;
   logic              stall;
   logic              fault_clr;
   logic [AWIDTH-1:0] pc;
   logic              pc_valid;
   logic              flush;
   logic              ras_full;
   logic              ras_empty;
   logic              fault;
   logic [1:0]        fault_code;

   modport master (
      output instr_valid, instr, immediate, rd, flag, stall, fault_clr,
      input  pc, pc_valid, flush, ras_full, ras_empty, fault, fault_code
   );

   modport slave (
      input  instr_valid, instr, immediate, rd, flag, stall, fault_clr,
      output pc, pc_valid, flush, ras_full, ras_empty, fault, fault_code
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a private return-address stack.
//
// Each accepted instruction produces the next fetch address one cycle later. JR, JPC,
// taken BRFL, CALL and RET redirect the PC and are followed by a one-cycle FLUSH state
// (flush=1, pc_valid=0). RAS overflow/underflow parks the sequencer in FAULT until
// fault_clr.
//
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  pc_sequencer_if.slave (instruction inputs, pc / status outputs)
//
// Build option: define PC_SEQ_RAS_OVERWRITE_EN to make the RAS circular; a CALL at full
// then overwrites the oldest entry instead of faulting. Default build faults on overflow.

module pc_sequencer #(
   parameter int unsigned DWIDTH    = 32,
   parameter int unsigned AWIDTH    = 15,
   parameter int unsigned RAS_DEPTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   pc_sequencer_if.slave        bus
);

   localparam int unsigned PtrW = $clog2(RAS_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

   localparam logic [4:0] OpJr   = 5'b01101;
   localparam logic [4:0] OpJpc  = 5'b01110;
   localparam logic [4:0] OpBrfl = 5'b01111;
   localparam logic [4:0] OpCall = 5'b10000;
   localparam logic [4:0] OpRet  = 5'b10001;

   localparam logic [1:0] CodeNone = 2'b00;
   localparam logic [1:0] CodeOvf  = 2'b01;
   localparam logic [1:0] CodeUnf  = 2'b10;

   typedef enum logic [1:0] {StRun, StFlush, StFault} state_e;

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] pc_q, pc_d;
   logic [1:0]        fault_code_q, fault_code_d;
   logic [PtrW-1:0]   wptr_q, wptr_d;   // next free slot; top of stack is wptr_q-1
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              ras_full_q, ras_empty_q;
   logic              push, pop;
   logic [AWIDTH-1:0] ras_mem [RAS_DEPTH];

   logic [4:0]        opcode;
   logic [AWIDTH-1:0] pc_inc;
   logic [AWIDTH-1:0] target;
   logic [AWIDTH-1:0] jpc_target;
   logic [AWIDTH-1:0] ras_top;

   // Operand bits above the address width and the instruction payload are not used here.
   logic unused_bits;
   assign unused_bits = ^{bus.instr[DWIDTH-6:0], bus.rd[DWIDTH-1:AWIDTH],
                          bus.immediate[DWIDTH-1:AWIDTH]};

   assign opcode     = bus.instr[DWIDTH-1:DWIDTH-5];
   assign pc_inc     = pc_q + AWIDTH'(1);
   assign target     = bus.rd[AWIDTH-1:0];
   assign jpc_target = pc_q + bus.immediate[AWIDTH-1:0] + AWIDTH'(1);
   assign ras_top    = ras_mem[wptr_q - PtrW'(1)];

   // Next-state / redirect decode.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fault_code_d = fault_code_q;
      push         = 1'b0;
      pop          = 1'b0;

      unique case (state_q)
         StRun: begin
            // stall wins over instr_valid; an idle cycle simply holds pc.
            if (!bus.stall && bus.instr_valid) begin
               case (opcode)
                  OpJr: begin
                     pc_d    = target;
                     state_d = StFlush;
                  end
                  OpJpc: begin
                     pc_d    = jpc_target;
                     state_d = StFlush;
                  end
                  OpBrfl: begin
                     if (bus.flag) begin
                        pc_d    = target;
                        state_d = StFlush;
                     end else begin
                        pc_d = pc_inc;
                     end
                  end
                  OpCall: begin
`ifdef PC_SEQ_RAS_OVERWRITE_EN
                     push    = 1'b1;
                     pc_d    = target;
                     state_d = StFlush;
`else
                     if (ras_full_q) begin
                        fault_code_d = CodeOvf;
                        state_d      = StFault;
                     end else begin
                        push    = 1'b1;
                        pc_d    = target;
                        state_d = StFlush;
                     end
`endif
                  end
                  OpRet: begin
                     if (ras_empty_q) begin
                        fault_code_d = CodeUnf;
                        state_d      = StFault;
                     end else begin
                        pop     = 1'b1;
                        pc_d    = ras_top;
                        state_d = StFlush;
                     end
                  end
                  default: pc_d = pc_inc;
               endcase
            end
         end
         StFlush: state_d = StRun;
         StFault: begin
            if (bus.fault_clr) begin
               fault_code_d = CodeNone;
               state_d      = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // RAS pointer and occupancy; the count saturates so a circular overwrite keeps it full.
   always_comb begin
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      if (push) begin
         wptr_d = wptr_q + PtrW'(1);
         if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
         end
      end else if (pop) begin
         wptr_d = wptr_q - PtrW'(1);
         cnt_d  = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StRun;
         pc_q         <= '0;
         fault_code_q <= CodeNone;
         wptr_q       <= '0;
         cnt_q        <= '0;
         ras_full_q   <= 1'b0;
         ras_empty_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fault_code_q <= fault_code_d;
         wptr_q       <= wptr_d;
         cnt_q        <= cnt_d;
         ras_full_q   <= (cnt_d == CntMax);
         ras_empty_q  <= (cnt_d == '0);
      end
   end

   // Stack storage needs no reset: the pointer and count define what is live.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         ras_mem[wptr_q] <= pc_inc;
      end
   end

   assign bus.pc         = pc_q;
   assign bus.pc_valid   = (state_q == StRun);
   assign bus.flush      = (state_q == StFlush);
   assign bus.fault      = (state_q == StFault);
   assign bus.fault_code = fault_code_q;
   assign bus.ras_full   = ras_full_q;
   assign bus.ras_empty  = ras_empty_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer.
// Each step drives one cycle of stimulus, queues the outputs expected after the next
// rising edge, then pops and compares them. Honours PC_SEQ_RAS_OVERWRITE_EN.

module tb_pc_sequencer;

   localparam int unsigned DWIDTH    = 32;
   localparam int unsigned AWIDTH    = 15;
   localparam int unsigned RAS_DEPTH = 32;

   localparam logic [4:0] OP_SEQ  = 5'b00000;
   localparam logic [4:0] OP_JR   = 5'b01101;
   localparam logic [4:0] OP_JPC  = 5'b01110;
   localparam logic [4:0] OP_BRFL = 5'b01111;
   localparam logic [4:0] OP_CALL = 5'b10000;
   localparam logic [4:0] OP_RET  = 5'b10001;

`ifdef PC_SEQ_RAS_OVERWRITE_EN
   localparam int RET_A = 1032;
   localparam int RET_B = 1031;
`else
   localparam int RET_A = 1031;
   localparam int RET_B = 1030;
`endif

   typedef struct packed {
      logic [AWIDTH-1:0] pc;
      logic [6:0]        flags;   // {pc_valid, flush, fault, fault_code[1:0], ras_full, ras_empty}
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     n_tests = 0;
   int     n_fail  = 0;
   exp_t   exp_q[$];
   string  tag_q[$];

   pc_sequencer_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) bus ();

   pc_sequencer #(
      .DWIDTH   (DWIDTH),
      .AWIDTH   (AWIDTH),
      .RAS_DEPTH(RAS_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic valid, input int rd_v, input int imm,
                        input logic flg, input logic stl, input logic clr);
      bus.instr       = {op, 27'd0};
      bus.instr_valid = valid;
      bus.rd          = DWIDTH'(rd_v);
      bus.immediate   = DWIDTH'(imm);
      bus.flag        = flg;
      bus.stall       = stl;
      bus.fault_clr   = clr;
   endtask

   task automatic idle();
      drive(OP_SEQ, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expect_out(input string tag, input int pc_v, input logic pv, input logic fl,
                             input logic flt, input logic [1:0] code, input logic full,
                             input logic empty);
      exp_t e;
      e.pc    = AWIDTH'(pc_v);
      e.flags = {pv, fl, flt, code, full, empty};
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Advance one clock and score the oldest pending expectation against the DUT.
   task automatic tick();
      exp_t  e;
      string t;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard: got an output cycle, expected a queued entry");
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check({t, ".pc"}, 32'(bus.pc), 32'(e.pc));
         check({t, ".flags"},
               32'({bus.pc_valid, bus.flush, bus.fault, bus.fault_code, bus.ras_full,
                    bus.ras_empty}),
               32'(e.flags));
      end
   endtask

   initial begin
      idle();
      rst = 1'b1;
      expect_out("reset", 0, 1, 0, 0, 2'b00, 0, 1);
      tick();
      rst = 1'b0;

      for (int i = 1; i <= 5; i++) begin
         drive(OP_SEQ, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
         expect_out("seq", i, 1, 0, 0, 2'b00, 0, 1);
         tick();
      end

      drive(OP_JPC, 1'b1, 0, 10, 1'b0, 1'b0, 1'b0);
      expect_out("jpc", 16, 0, 1, 0, 2'b00, 0, 1);
      tick();
      // A valid instruction during FLUSH must be ignored.
      drive(OP_SEQ, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
      expect_out("jpc_flush_ignore", 16, 1, 0, 0, 2'b00, 0, 1);
      tick();

      drive(OP_JR, 1'b1, 7, 0, 1'b0, 1'b0, 1'b0);
      expect_out("jr", 7, 0, 1, 0, 2'b00, 0, 1);
      tick();
      idle();
      expect_out("jr_run", 7, 1, 0, 0, 2'b00, 0, 1);
      tick();

      drive(OP_BRFL, 1'b1, 100, 0, 1'b0, 1'b0, 1'b0);
      expect_out("brfl_nt", 8, 1, 0, 0, 2'b00, 0, 1);
      tick();
      drive(OP_BRFL, 1'b1, 100, 0, 1'b1, 1'b0, 1'b0);
      expect_out("brfl_t", 100, 0, 1, 0, 2'b00, 0, 1);
      tick();
      idle();
      expect_out("brfl_run", 100, 1, 0, 0, 2'b00, 0, 1);
      tick();

      drive(OP_JR, 1'b1, 4, 0, 1'b0, 1'b0, 1'b0);
      expect_out("jr4", 4, 0, 1, 0, 2'b00, 0, 1);
      tick();
      idle();
      expect_out("jr4_run", 4, 1, 0, 0, 2'b00, 0, 1);
      tick();

      drive(OP_CALL, 1'b1, 200, 0, 1'b0, 1'b0, 1'b0);
      expect_out("call", 200, 0, 1, 0, 2'b00, 0, 0);
      tick();
      idle();
      expect_out("call_run", 200, 1, 0, 0, 2'b00, 0, 0);
      tick();
      drive(OP_RET, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
      expect_out("ret", 5, 0, 1, 0, 2'b00, 0, 1);
      tick();
      idle();
      expect_out("ret_run", 5, 1, 0, 0, 2'b00, 0, 1);
      tick();

      drive(OP_CALL, 1'b1, 300, 0, 1'b0, 1'b1, 1'b0);
      expect_out("stall_call", 5, 1, 0, 0, 2'b00, 0, 1);
      tick();
      idle();
      expect_out("hold", 5, 1, 0, 0, 2'b00, 0, 1);
      tick();

      // Fill the RAS: call i targets 1000+i and pushes its own pc+1.
      for (int i = 0; i < 32; i++) begin
         drive(OP_CALL, 1'b1, 1000 + i, 0, 1'b0, 1'b0, 1'b0);
         expect_out("call_fill", 1000 + i, 0, 1, 0, 2'b00, (i == 31), 0);
         tick();
         idle();
         expect_out("call_fill_run", 1000 + i, 1, 0, 0, 2'b00, (i == 31), 0);
         tick();
      end

`ifdef PC_SEQ_RAS_OVERWRITE_EN
      drive(OP_CALL, 1'b1, 2000, 0, 1'b0, 1'b0, 1'b0);
      expect_out("call_wrap", 2000, 0, 1, 0, 2'b00, 1, 0);
      tick();
      idle();
      expect_out("call_wrap_run", 2000, 1, 0, 0, 2'b00, 1, 0);
      tick();
`else
      drive(OP_CALL, 1'b1, 2000, 0, 1'b0, 1'b0, 1'b0);
      expect_out("call_ovf", 1031, 0, 0, 1, 2'b01, 1, 0);
      tick();
      drive(OP_CALL, 1'b1, 2000, 0, 1'b0, 1'b0, 1'b0);
      expect_out("ovf_hold", 1031, 0, 0, 1, 2'b01, 1, 0);
      tick();
      drive(OP_SEQ, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      expect_out("ovf_clr", 1031, 1, 0, 0, 2'b00, 1, 0);
      tick();
`endif

      drive(OP_JR, 1'b1, 50, 0, 1'b0, 1'b0, 1'b0);
      expect_out("jr50", 50, 0, 1, 0, 2'b00, 1, 0);
      tick();
      idle();
      expect_out("jr50_run", 50, 1, 0, 0, 2'b00, 1, 0);
      tick();
      drive(OP_RET, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
      expect_out("ret_a", RET_A, 0, 1, 0, 2'b00, 0, 0);
      tick();
      idle();
      expect_out("ret_a_run", RET_A, 1, 0, 0, 2'b00, 0, 0);
      tick();
      drive(OP_RET, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
      expect_out("ret_b", RET_B, 0, 1, 0, 2'b00, 0, 0);
      tick();
      idle();
      expect_out("ret_b_run", RET_B, 1, 0, 0, 2'b00, 0, 0);
      tick();

      // Reset while a flush is pending.
      drive(OP_JR, 1'b1, 9, 0, 1'b0, 1'b0, 1'b0);
      expect_out("jr9", 9, 0, 1, 0, 2'b00, 0, 0);
      tick();
      idle();
      rst = 1'b1;
      expect_out("rst_flush", 0, 1, 0, 0, 2'b00, 0, 1);
      tick();
      rst = 1'b0;

      drive(OP_SEQ, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
      expect_out("seq_post_rst", 1, 1, 0, 0, 2'b00, 0, 1);
      tick();
      drive(OP_RET, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
      expect_out("ret_unf", 1, 0, 0, 1, 2'b10, 0, 1);
      tick();
      idle();
      expect_out("unf_hold", 1, 0, 0, 1, 2'b10, 0, 1);
      tick();
      // rst takes priority over fault_clr.
      drive(OP_SEQ, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      expect_out("rst_fault", 0, 1, 0, 0, 2'b00, 0, 1);
      tick();
      rst = 1'b0;
      idle();
      expect_out("post_rst", 0, 1, 0, 0, 2'b00, 0, 1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
